// File: rtl/clk_div_monitor.sv
// Divider self-check: synchronizes an even-ratio divider output, measures its
// period and high time in clk cycles, and tracks lock with a sticky loss-of-lock flag.
module clk_div_monitor #(
    parameter int DIV_RATIO = 4,
    parameter int CNT_W     = 8,
    parameter int LOCK_CNT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             err_clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  ONE_V   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  MAX_V   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  RATIO_V = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0]  HALF_V  = CNT_W'(DIV_RATIO / 2);
    localparam logic [CNT_W-1:0]  TMO_V   = CNT_W'(2 * DIV_RATIO);
    localparam logic [GOOD_W-1:0] LOCK_V  = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_UNARMED  = 2'd0,
        ST_ARMED    = 2'd1,
        ST_COUNTING = 2'd2,
        ST_LOCKED   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]  hi_meas_q, hi_meas_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              rise_pulse_q, rise_pulse_d;
    logic              fall_pulse_q, fall_pulse_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_time_q, high_time_d;
    logic              period_valid_q, period_valid_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    logic rise, fall, timeout, measure, good_meas, lose;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_UNARMED;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            per_cnt_q      <= '0;
            hi_cnt_q       <= '0;
            hi_meas_q      <= '0;
            good_cnt_q     <= '0;
            rise_pulse_q   <= 1'b0;
            fall_pulse_q   <= 1'b0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            per_cnt_q      <= per_cnt_d;
            hi_cnt_q       <= hi_cnt_d;
            hi_meas_q      <= hi_meas_d;
            good_cnt_q     <= good_cnt_d;
            rise_pulse_q   <= rise_pulse_d;
            fall_pulse_q   <= fall_pulse_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
        end
    end

    // Synchronizer, edge detection and the two measurement counters.
    always_comb begin
        s1_d = div_in;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;

        per_cnt_d = (per_cnt_q == MAX_V) ? MAX_V : per_cnt_q + ONE_V;
        if (rise) per_cnt_d = ONE_V;

        hi_cnt_d = hi_cnt_q;
        if (rise) hi_cnt_d = ONE_V;
        else if (s2_q && hi_cnt_q != MAX_V) hi_cnt_d = hi_cnt_q + ONE_V;

        hi_meas_d = fall ? hi_cnt_q : hi_meas_q;

        timeout   = ~rise && (per_cnt_q == TMO_V);
        measure   = rise && (state_q != ST_UNARMED);
        good_meas = (per_cnt_q == RATIO_V) && (hi_meas_q == HALF_V);
    end

    // Lock FSM; a timeout can only occur in a cycle without a rising edge.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        lose       = 1'b0;
        if (timeout) begin
            state_d    = ST_UNARMED;
            good_cnt_d = '0;
            lose       = locked_q;
        end else if (rise) begin
            if (state_q == ST_UNARMED) begin
                state_d = ST_ARMED;
            end else if (good_meas) begin
                good_cnt_d = (good_cnt_q == LOCK_V) ? LOCK_V : good_cnt_q + GOOD_W'(1);
                state_d    = (good_cnt_d == LOCK_V) ? ST_LOCKED : ST_COUNTING;
            end else begin
                good_cnt_d = '0;
                state_d    = ST_ARMED;
                lose       = locked_q;
            end
        end
    end

    // Registered outputs; locked follows the LOCKED state one edge late but drops at once.
    always_comb begin
        rise_pulse_d   = rise;
        fall_pulse_d   = fall;
        period_valid_d = measure;
        period_d       = measure ? per_cnt_q : period_q;
        high_time_d    = measure ? hi_meas_q : high_time_q;
        locked_d       = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
        err_d          = err_q;
        if (err_clr) err_d = 1'b0;
        if (lose) err_d = 1'b1;
    end

    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;
    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign state_dbg    = state_q;

endmodule
